// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scanout of a 160x120 4bpp framebuffer.
// Drives the read port of the dual-port framebuffer RAM.
module vga_fb_scanout #(
   parameter int BASE_ADDR = 0,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [11:0] mem_address,
   output logic        mem_chipselect,
   input  logic [31:0] mem_readdata,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);

   typedef logic [9:0] cnt_t;

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
   localparam cnt_t H_PRE  = cnt_t'(H_TOT - 2);
   localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
   localparam cnt_t H_WLIM = cnt_t'(H_ACTIVE - 32);
   localparam cnt_t HS_ON  = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_OFF = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
   localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
   localparam cnt_t VS_ON  = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_OFF = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [11:0] BASE   = 12'(BASE_ADDR);
   localparam logic [11:0] STRIDE = 12'(H_ACTIVE / 32);

   cnt_t        h_cnt;
   cnt_t        v_cnt;
   logic [11:0] line_base;
   logic        en_q;
   logic        fetch_q;
   logic [31:0] cur_word;
   logic [31:0] next_word;

   logic        h_wrap;
   logic        v_wrap;
   cnt_t        v_nxt;
   logic [11:0] base_nxt;
   logic        vis_line;
   logic        visible;
   logic        top;
   logic        en_cur;
   logic        pre_en;
   logic        fetch_first;
   logic        fetch_word;
   logic [31:0] wsel;
   logic [3:0]  nib;
   logic [23:0] rgb_d;

   function automatic logic [7:0] expand(input logic c, input logic i);
      if (c) return i ? 8'hFF : 8'hAA;
      return i ? 8'h55 : 8'h00;
   endfunction

   assign h_wrap   = (h_cnt == H_LAST);
   assign v_wrap   = (v_cnt == V_LAST);
   assign v_nxt    = v_wrap ? '0 : v_cnt + 10'd1;
   assign base_nxt = v_wrap ? BASE :
                     (v_cnt[1:0] == 2'd3) ? line_base + STRIDE :
                     line_base;
   assign vis_line = (v_cnt < V_VIS);
   assign visible  = vis_line && (h_cnt < H_VIS);
   assign top      = (h_cnt == '0) && (v_cnt == '0);

   // The frame's enable is decided at (0,0); line 0's first word is
   // prefetched on the last line, so that fetch follows the live input.
   assign en_cur = top ? enable : en_q;
   assign pre_en = v_wrap ? enable : en_q;

   assign fetch_first = (h_cnt == H_PRE) && (v_nxt < V_VIS) && pre_en;
   assign fetch_word  = en_q && vis_line && (h_cnt[4:0] == 5'd30) &&
                        (h_cnt < H_WLIM);

   always_comb begin
      mem_chipselect = 1'b0;
      mem_address    = line_base;
      unique case (1'b1)
         fetch_first: begin
            mem_chipselect = 1'b1;
            mem_address    = base_nxt;
         end
         fetch_word: begin
            mem_chipselect = 1'b1;
            mem_address    = line_base + {7'd0, h_cnt[9:5]} + 12'd1;
         end
         default: ;
      endcase
   end

   // At a word boundary the freshly fetched word is shown directly.
   assign wsel  = (h_cnt[4:0] == 5'd0) ? next_word : cur_word;
   assign nib   = wsel[{h_cnt[4:2], 2'b00} +: 4];
   assign rgb_d = (visible && en_cur) ?
                  {expand(nib[2], nib[3]),
                   expand(nib[1], nib[3]),
                   expand(nib[0], nib[3])} : 24'd0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         line_base   <= BASE;
         en_q        <= 1'b0;
         fetch_q     <= 1'b0;
         cur_word    <= '0;
         next_word   <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         frame_start <= 1'b0;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
         if (h_wrap) begin
            v_cnt     <= v_nxt;
            line_base <= base_nxt;
         end
         if (top) en_q <= enable;
         fetch_q <= mem_chipselect;
         if (fetch_q) next_word <= mem_readdata;
         if (visible && (h_cnt[4:0] == 5'd0)) cur_word <= next_word;
         vga_hs      <= !((h_cnt >= HS_ON) && (h_cnt < HS_OFF));
         vga_vs      <= !((v_cnt >= VS_ON) && (v_cnt < VS_OFF));
         vga_blank_n <= visible;
         {vga_r, vga_g, vga_b} <= rgb_d;
         frame_start <= top;
      end
   end

endmodule
